// File: rtl/lut_coeff_access_ctrl.sv
// Arbitration between pipeline reads and whole-table coefficient reloads on one
// single-port LUT. Reloads drain in-flight reads first and then own the RAM port.
module lut_coeff_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 3584,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          INIT_VALID = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  load_start,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  load_done,
    output logic                  coeff_valid,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [1:0] {INVALID, READY, DRAIN, LOAD} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam state_t                RST_STATE = INIT_VALID ? READY : INVALID;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [RD_LATENCY:1]   vld_pipe;
    logic                  rd_accept;
    logic                  ld_write;
    logic                  ld_last;

    // load_start wins over a same-cycle read so the drain never has to chase a new one
    assign rd_ready  = (state == READY) && !load_start;
    assign rd_accept = rd_req && rd_ready;
    assign ld_ready  = (state == LOAD);
    assign ld_write  = ld_ready && ld_valid;
    assign ld_last   = ld_write && (wr_ptr == LAST_ADDR);
    assign rd_valid  = vld_pipe[RD_LATENCY];
    assign rd_data   = ram_q;
    assign ram_data  = ld_data;

    always_comb begin
        ram_address = rd_addr;
        ram_rden    = rd_accept;
        ram_wren    = 1'b0;
        if (state == LOAD) begin
            ram_address = wr_ptr;
            ram_rden    = 1'b0;
            ram_wren    = ld_valid;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INVALID: if (load_start)        state_nxt = LOAD;
            READY:   if (load_start)        state_nxt = DRAIN;
            DRAIN:   if (vld_pipe == '0)    state_nxt = LOAD;
            LOAD:    if (ld_last)           state_nxt = READY;
            default:                        state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RST_STATE;
            wr_ptr      <= '0;
            vld_pipe    <= '0;
            load_done   <= 1'b0;
            coeff_valid <= INIT_VALID;
        end else begin
            state       <= state_nxt;
            vld_pipe[1] <= rd_accept;
            for (int i = 2; i <= int'(RD_LATENCY); i++)
                vld_pipe[i] <= vld_pipe[i-1];
            if (ld_write)
                wr_ptr <= ld_last ? '0 : wr_ptr + 1'b1;
            load_done <= ld_last;
            if (ld_last)
                coeff_valid <= 1'b1;
            else if (state == READY && load_start)
                coeff_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lut_coeff_access_ctrl.sv
// Bench for lut_coeff_access_ctrl: three instances (init-valid/lat1, init-invalid/lat1,
// init-valid/lat2), each with its own behavioural single-port LUT.
module tb_lut_coeff_access_ctrl;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        init_mem;
    logic        rst        [NI];
    logic        rd_req     [NI];
    logic [3:0]  rd_addr    [NI];
    logic        rd_ready   [NI];
    logic        rd_valid   [NI];
    logic [31:0] rd_data    [NI];
    logic        load_start [NI];
    logic        ld_valid   [NI];
    logic [31:0] ld_data    [NI];
    logic        ld_ready   [NI];
    logic        load_done  [NI];
    logic        coeff_valid[NI];
    logic [3:0]  ram_address[NI];
    logic [31:0] ram_data   [NI];
    logic        ram_rden   [NI];
    logic        ram_wren   [NI];
    logic [31:0] ram_q      [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam bit          IV  = (g != 1);
        localparam int unsigned LAT = (g == 2) ? 2 : 1;

        lut_coeff_access_ctrl #(
            .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .RD_LATENCY(LAT), .INIT_VALID(IV)
        ) u_dut (
            .clk(clk), .rst(rst[g]),
            .rd_req(rd_req[g]), .rd_addr(rd_addr[g]), .rd_ready(rd_ready[g]),
            .rd_valid(rd_valid[g]), .rd_data(rd_data[g]),
            .load_start(load_start[g]), .ld_valid(ld_valid[g]), .ld_data(ld_data[g]),
            .ld_ready(ld_ready[g]), .load_done(load_done[g]), .coeff_valid(coeff_valid[g]),
            .ram_address(ram_address[g]), .ram_data(ram_data[g]),
            .ram_rden(ram_rden[g]), .ram_wren(ram_wren[g]), .ram_q(ram_q[g])
        );

        logic [31:0] mem [16];
        logic [31:0] q1, q2;
        always @(posedge clk) begin
            if (init_mem) begin
                for (int i = 0; i < 16; i++) mem[i] <= 32'hA000 + 32'(i);
            end else if (ram_wren[g]) begin
                mem[ram_address[g]] <= ram_data[g];
            end
            if (ram_rden[g]) q1 <= mem[ram_address[g]];
            q2 <= q1;
        end
        assign ram_q[g] = (LAT == 1) ? q1 : q2;
    end

    function automatic int lat(int g);
        return (g == 2) ? 2 : 1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkb(string name, logic act, logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    task automatic drive(int g, bit rq, bit [3:0] a, bit ls, bit lv, bit [31:0] d);
        rd_req[g]     = rq;
        rd_addr[g]    = a;
        load_start[g] = ls;
        ld_valid[g]   = lv;
        ld_data[g]    = d;
    endtask

    // wren and rden must never overlap on any instance
    always @(negedge clk) begin
        #2;
        for (int g = 0; g < NI; g++)
            if (rst[g] === 1'b1) chkb($sformatf("excl_i%0d", g), ram_wren[g] & ram_rden[g], 1'b0);
    end

    task automatic wait_load(int g);
        bit got = 1'b0;
        @(negedge clk); drive(g, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0); #1;
        chkb($sformatf("ls_ld_ready_i%0d", g), ld_ready[g], 1'b0);
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk); drive(g, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0); #1;
            chkb($sformatf("wl_coeff_i%0d", g), coeff_valid[g], 1'b0);
            got = ld_ready[g];
        end
        chkb($sformatf("wl_entry_i%0d", g), got, 1'b1);
    endtask

    task automatic load_words(int g, logic [31:0] base, bit gap, int ls_at);
        for (int i = 0; i < 16; i++) begin
            if (gap) begin
                @(negedge clk); drive(g, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0); #1;
                chkb($sformatf("gap_wren_i%0d_w%0d", g, i), ram_wren[g], 1'b0);
                chk($sformatf("gap_ptr_i%0d_w%0d", g, i), 32'(ram_address[g]), 32'(i));
            end
            @(negedge clk); drive(g, 1'b0, 4'd0, i == ls_at, 1'b1, base + 32'(i)); #1;
            chkb($sformatf("ld_ready_i%0d_w%0d", g, i), ld_ready[g], 1'b1);
            chkb($sformatf("wren_i%0d_w%0d", g, i), ram_wren[g], 1'b1);
            chkb($sformatf("rden_i%0d_w%0d", g, i), ram_rden[g], 1'b0);
            chk($sformatf("waddr_i%0d_w%0d", g, i), 32'(ram_address[g]), 32'(i));
            chk($sformatf("wdata_i%0d_w%0d", g, i), ram_data[g], base + 32'(i));
        end
        @(negedge clk); drive(g, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0); #1;
        chkb($sformatf("done_i%0d", g), load_done[g], 1'b1);
        chkb($sformatf("coeff_after_i%0d", g), coeff_valid[g], 1'b1);
        chkb($sformatf("rdy_after_i%0d", g), rd_ready[g], 1'b1);
        chkb($sformatf("ldrdy_after_i%0d", g), ld_ready[g], 1'b0);
        @(negedge clk); #1;
        chkb($sformatf("done_pulse_i%0d", g), load_done[g], 1'b0);
    endtask

    task automatic read_check(int g, bit [3:0] a, logic [31:0] exp);
        @(negedge clk); drive(g, 1'b1, a, 1'b0, 1'b0, 32'h0); #1;
        chkb($sformatf("rd_ready_i%0d_a%0d", g, a), rd_ready[g], 1'b1);
        for (int c = 1; c <= lat(g); c++) begin
            @(negedge clk); drive(g, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0); #1;
            chkb($sformatf("rd_valid_i%0d_a%0d_c%0d", g, a, c), rd_valid[g], c == lat(g));
        end
        chk($sformatf("rd_data_i%0d_a%0d", g, a), rd_data[g], exp);
    endtask

    typedef struct {
        bit        rd_req;
        bit [3:0]  rd_addr;
        bit        load_start;
        bit        ld_valid;
        bit [31:0] ld_data;
        bit        e_rd_ready;
        bit        e_rden;
        bit        e_wren;
        bit        e_ld_ready;
        bit        e_rd_valid;
        bit [31:0] e_rd_data;
        bit        e_coeff;
        bit        e_done;
    } vec_t;

    vec_t vt[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1'b1, 4'd3, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0};
        vt[1] = '{1'b1, 4'd4, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA003, 1'b1, 1'b0};
        vt[2] = '{1'b1, 4'd5, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA004, 1'b1, 1'b0};
        vt[3] = '{1'b0, 4'd0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA005, 1'b1, 1'b0};
        vt[4] = '{1'b0, 4'd0, 1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0};
        vt[5] = '{1'b1, 4'd0, 1'b0, 1'b1, 32'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0};
        vt[6] = '{1'b0, 4'd0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000, 1'b1, 1'b0};

        init_mem = 1'b1;
        for (int g = 0; g < NI; g++) begin
            rst[g] = 1'b0;
            drive(g, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chkb("rst_rdy_i0", rd_ready[0], 1'b1);
        chkb("rst_coeff_i0", coeff_valid[0], 1'b1);
        chkb("rst_vld_i0", rd_valid[0], 1'b0);
        chkb("rst_done_i0", load_done[0], 1'b0);
        chkb("rst_rdy_i1", rd_ready[1], 1'b0);
        chkb("rst_coeff_i1", coeff_valid[1], 1'b0);
        chkb("rst_ldrdy_i2", ld_ready[2], 1'b0);
        @(negedge clk);
        init_mem = 1'b0;
        for (int g = 0; g < NI; g++) rst[g] = 1'b1;

        // T1 + T6 (READY side): table of per-cycle vectors on instance 0
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drive(0, vt[k].rd_req, vt[k].rd_addr, vt[k].load_start, vt[k].ld_valid, vt[k].ld_data);
            #1;
            chkb($sformatf("v%0d_rd_ready", k), rd_ready[0], vt[k].e_rd_ready);
            chkb($sformatf("v%0d_rden", k), ram_rden[0], vt[k].e_rden);
            chkb($sformatf("v%0d_wren", k), ram_wren[0], vt[k].e_wren);
            chkb($sformatf("v%0d_ld_ready", k), ld_ready[0], vt[k].e_ld_ready);
            chkb($sformatf("v%0d_rd_valid", k), rd_valid[0], vt[k].e_rd_valid);
            if (vt[k].e_rd_valid) chk($sformatf("v%0d_rd_data", k), rd_data[0], vt[k].e_rd_data);
            chkb($sformatf("v%0d_coeff", k), coeff_valid[0], vt[k].e_coeff);
            chkb($sformatf("v%0d_done", k), load_done[0], vt[k].e_done);
        end

        // T2: INIT_VALID=0 blocks reads until a contiguous load completes
        @(negedge clk); drive(1, 1'b1, 4'd7, 1'b0, 1'b0, 32'h0); #1;
        chkb("t2_rdy_invalid", rd_ready[1], 1'b0);
        chkb("t2_rden_invalid", ram_rden[1], 1'b0);
        wait_load(1);
        load_words(1, 32'h100, 1'b0, -1);
        read_check(1, 4'd7, 32'h107);

        // T3: reload with gaps, then read back the whole table
        wait_load(1);
        load_words(1, 32'h200, 1'b1, -1);
        for (int a = 0; a < 16; a++) read_check(1, 4'(a), 32'h200 + 32'(a));

        // T4: load_start collides with a read while one is in flight (latency 2)
        @(negedge clk); drive(2, 1'b1, 4'd9, 1'b0, 1'b0, 32'h0); #1;
        chkb("t4_accept_first", rd_ready[2], 1'b1);
        @(negedge clk); drive(2, 1'b1, 4'd10, 1'b1, 1'b0, 32'h0); #1;
        chkb("t4_reject_rdy", rd_ready[2], 1'b0);
        chkb("t4_reject_rden", ram_rden[2], 1'b0);
        @(negedge clk); drive(2, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0); #1;
        chkb("t4_inflight_vld", rd_valid[2], 1'b1);
        chk("t4_inflight_data", rd_data[2], 32'hA009);
        chkb("t4_coeff_drop", coeff_valid[2], 1'b0);
        chkb("t4_drain_ldrdy", ld_ready[2], 1'b0);
        @(negedge clk); #1;
        chkb("t4_no_second_vld", rd_valid[2], 1'b0);
        chkb("t4_coeff_drain", coeff_valid[2], 1'b0);
        begin
            bit got = ld_ready[2];
            for (int k = 0; k < 4 && !got; k++) begin
                @(negedge clk); #1;
                chkb("t4_coeff_wait", coeff_valid[2], 1'b0);
                got = ld_ready[2];
            end
            chkb("t4_load_entry", got, 1'b1);
        end
        load_words(2, 32'h300, 1'b0, -1);
        read_check(2, 4'd10, 32'h30A);

        // T5: reset mid-load aborts, then a fresh load (with a stray load_start) succeeds
        wait_load(0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); drive(0, 1'b0, 4'd0, 1'b0, 1'b1, 32'h400 + 32'(i)); #1;
            chkb($sformatf("t5_part_wren_%0d", i), ram_wren[0], 1'b1);
        end
        @(negedge clk); drive(0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0); rst[0] = 1'b0;
        @(negedge clk); rst[0] = 1'b1; drive(0, 1'b0, 4'd0, 1'b0, 1'b1, 32'hBAD); #1;
        chkb("t5_wren_after_rst", ram_wren[0], 1'b0);
        chkb("t5_ldrdy_after_rst", ld_ready[0], 1'b0);
        chkb("t5_rdy_after_rst", rd_ready[0], 1'b1);
        chkb("t5_done_after_rst", load_done[0], 1'b0);
        chkb("t5_coeff_after_rst", coeff_valid[0], 1'b1);
        wait_load(0);
        load_words(0, 32'h500, 1'b0, 5);
        read_check(0, 4'd2, 32'h502);
        read_check(0, 4'd12, 32'h50C);
        read_check(0, 4'd15, 32'h50F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
